// File: rtl/pc_load_master.sv
// pc_load_master: sequencer driving the PC counter's {oe,load,en} controls and its shared-bus load protocol
module pc_load_master #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 1,
  parameter int VERIFY      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             run,
  input  logic             rd_en,
  output logic [2:0]       ctrl_out,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic [WIDTH-1:0] pc_value,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PULSE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRIVE = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oe_q, oe_d, load_q, load_d, en_q, en_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             bus_oe_q, bus_oe_d, done_q, done_d, err_q, err_d;
  logic             accept, restore, wait_end;
  // Next-state: WAIT covers the counter's N-stage sync plus its bus-release cycle before we drive
  always_comb begin
    accept   = req_valid && state_q == IDLE;
    wait_end = state_q == WAIT && cnt_q == CW'(SYNC_STAGES);
    restore  = (VERIFY != 0) ? state_q == CHECK : state_q == DRIVE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE:    state_d = accept ? PULSE : IDLE;
      PULSE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        state_d = wait_end ? DRIVE : WAIT;
        cnt_d   = cnt_q + CW'(1);
      end
      DRIVE:   state_d = (VERIFY != 0) ? CHECK : IDLE;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_d   = accept;
    en_d     = run;
    oe_d     = ((state_q == IDLE && !accept) || restore) ? rd_en : 1'b0;
    bus_d    = accept ? req_data : bus_q;
    bus_oe_d = wait_end;
    done_d   = restore;
    err_d    = VERIFY != 0 && state_q == CHECK && pc_value != bus_q;
  end
  // All outputs registered; async reset drops bus drive immediately, mid-sequence included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      oe_q     <= 1'b0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      bus_q    <= '0;
      bus_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      load_q   <= load_d;
      en_q     <= en_d;
      bus_q    <= bus_d;
      bus_oe_q <= bus_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign ctrl_out  = {oe_q, load_q, en_q};
  assign bus_out   = bus_q;
  assign bus_oe    = bus_oe_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = state_q != IDLE;
  assign req_ready = state_q == IDLE;
endmodule
